// File: rtl/sha256_nonce_sequencer.sv
// sha256_nonce_sequencer: runs one shared SHA-256 compression core twice per
// nonce (header block 2 from the midstate, then the padded digest from the IV).
// It presents each nonce and its final digest on a valid/ready result stream.
// Optional feature macro: NONCE_TARGET_FILTER_EN adds a 256-bit target input.
// With the macro defined, only digests <= target are emitted.
`timescale 1ns/1ps
module sha256_nonce_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [255:0]     midstate,
  input  logic [95:0]      tail,
  input  logic [31:0]      nonce_base,
  input  logic [CNT_W-1:0] nonce_count,
`ifdef NONCE_TARGET_FILTER_EN
  input  logic [255:0]     target,
`endif
  output logic             busy,
  output logic             sweep_done,
  output logic             err,
  output logic             core_start,
  output logic [511:0]     core_block,
  output logic [255:0]     core_h,
  input  logic [255:0]     core_h_o,
  input  logic             core_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_nonce,
  output logic [255:0]     res_hash
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, EMIT} state_t;

  state_t           state;
  logic [255:0]     midstate_q;
  logic [95:0]      tail_q;
  logic [31:0]      nonce;
  logic [CNT_W-1:0] remaining;
  logic [255:0]     digest1;
  logic [TW-1:0]    wait_cnt;

  logic             last_nonce;
  logic             core_fin;
  logic             timed_out;
  logic             hash_ok;
  logic [511:0]     blk1;
  logic [511:0]     blk2;

  // The header stores the nonce little-endian, so its SHA word is byte-swapped.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

`ifdef NONCE_TARGET_FILTER_EN
  // Bitcoin reads the digest bytes little-endian: byte-reverse the whole vector
  // so that H7's last byte becomes the most significant.
  function automatic logic [255:0] rev_bytes(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction
  assign hash_ok = (rev_bytes(core_h_o) <= rev_bytes(target));
`else
  assign hash_ok = 1'b1;
`endif

  assign last_nonce = (remaining == CNT_W'(1));
  // The first WAIT cycle still shows the core's pre-start done level, so it is skipped.
  assign core_fin   = (wait_cnt != '0) && core_done;
  assign timed_out  = (wait_cnt == TW'(TIMEOUT - 1));
  assign blk1 = {tail_q, bswap32(nonce), 32'h80000000, 320'd0, 32'h00000280};
  assign blk2 = {digest1, 32'h80000000, 192'd0, 32'h00000100};

  // Sweep control: issue/wait per pass, emit results, count nonces, catch core hangs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
      core_block <= '0;
      core_h     <= '0;
      res_valid  <= 1'b0;
      res_nonce  <= '0;
      res_hash   <= '0;
      midstate_q <= '0;
      tail_q     <= '0;
      nonce      <= '0;
      remaining  <= '0;
      digest1    <= '0;
      wait_cnt   <= '0;
    end else begin
      sweep_done <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (nonce_count != '0) begin
              midstate_q <= midstate;
              tail_q     <= tail;
              nonce      <= nonce_base;
              remaining  <= nonce_count;
              err        <= 1'b0;
              busy       <= 1'b1;
              state      <= P1_ISSUE;
            end else begin
              sweep_done <= 1'b1;
            end
          end
        end
        P1_ISSUE, P2_ISSUE: begin
          if (core_done) begin
            core_start <= 1'b1;
            wait_cnt   <= '0;
            if (state == P1_ISSUE) begin
              core_h     <= midstate_q;
              core_block <= blk1;
              state      <= P1_WAIT;
            end else begin
              core_h     <= SHA_IV;
              core_block <= blk2;
              state      <= P2_WAIT;
            end
          end
        end
        P1_WAIT, P2_WAIT: begin
          if (core_fin) begin
            if (state == P1_WAIT) begin
              digest1 <= core_h_o;
              state   <= P2_ISSUE;
            end else if (hash_ok) begin
              res_hash  <= core_h_o;
              res_nonce <= nonce;
              res_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              // Filtered out: advance to the next nonce without emitting.
              nonce     <= nonce + 32'd1;
              remaining <= remaining - CNT_W'(1);
              if (last_nonce) begin
                sweep_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                state <= P1_ISSUE;
              end
            end
          end else if (timed_out) begin
            err        <= 1'b1;
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            nonce     <= nonce + 32'd1;
            remaining <= remaining - CNT_W'(1);
            if (last_nonce) begin
              sweep_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= P1_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
